// File: rtl/onewire_tx_sequencer.sv
// onewire_tx_sequencer
//
// Master-side controller for the 1-wire output driver. It runs one complete
// transfer per accepted request. A transfer is a reset/presence cycle, then
// 1..MAX_BITS data bits sent LSB first, then exactly one status pulse.
//
// Ports
//   clk               system clock, shared with the driver
//   reset             asynchronous, active-high reset, shared with the driver
//   i_req             transfer request, accepted only while o_ready=1
//   i_data            frame to send; bit 0 goes on the wire first
//   i_nbits           number of bits to send, legal range 1..MAX_BITS
//   o_ready           high while idle and able to accept a request
//   o_done            one-cycle pulse: transfer completed
//   o_err_presence    one-cycle pulse: driver finished reset, no presence
//   o_err_len         one-cycle pulse: request rejected, illegal i_nbits
//   o_err_timeout     one-cycle pulse: driver handshake went silent too long
//   o_drv_start       one-cycle pulse to the driver start input
//   o_drv_serial      next data bit for the driver (shift register bit 0)
//   o_drv_bit_strobe  level, high while bits remain to be handed over
//   i_drv_busy        driver busy flag (registered inside the driver)
//   i_drv_done_reset  driver reset-done flag, one cycle before bit 0 is taken
//   i_drv_done_1bit   driver bit-done flag, the cycle strobe/serial are taken
module onewire_tx_sequencer #(
  parameter int MAX_BITS    = 64,
  parameter int CNT_W       = 7,
  parameter int WDOG_CYCLES = 2048
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [CNT_W-1:0]    i_nbits,
  output logic                o_ready,
  output logic                o_done,
  output logic                o_err_presence,
  output logic                o_err_len,
  output logic                o_err_timeout,
  output logic                o_drv_start,
  output logic                o_drv_serial,
  output logic                o_drv_bit_strobe,
  input  logic                i_drv_busy,
  input  logic                i_drv_done_reset,
  input  logic                i_drv_done_1bit
);

  // The watchdog never needs to hold more than WDOG_CYCLES-1.
  localparam int WD_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_BITS);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT_PRES,
    SEND,
    FINISH
  } state_t;

  state_t              state, state_n;
  logic [MAX_BITS-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]    rem, rem_n;
  logic [WD_W-1:0]     wdog, wdog_n;
  logic                pres_dly, pres_dly_n;
  logic                done_q, done_n;
  logic                err_pres_q, err_pres_n;
  logic                err_len_q, err_len_n;
  logic                err_to_q, err_to_n;

  logic                len_ok;
  logic                wdog_hit;

  assign len_ok   = (i_nbits != '0) && (i_nbits <= MAX_N);
  assign wdog_hit = (wdog == WD_LIMIT);

  // Status pulses come from flops so each one is a clean single-cycle pulse
  // in the cycle after the condition that caused it. Drive start and the
  // data path are decoded from state and the shift register.
  assign o_ready          = (state == IDLE);
  assign o_done           = done_q;
  assign o_err_presence   = err_pres_q;
  assign o_err_len        = err_len_q;
  assign o_err_timeout    = err_to_q;
  assign o_drv_serial     = shreg[0];
  assign o_drv_bit_strobe = (rem != '0);

  // State and datapath register. Reset aborts any transfer silently: every
  // status flop clears, so no pulse escapes after a mid-transfer reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      rem        <= '0;
      wdog       <= '0;
      pres_dly   <= 1'b0;
      done_q     <= 1'b0;
      err_pres_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      rem        <= rem_n;
      wdog       <= wdog_n;
      pres_dly   <= pres_dly_n;
      done_q     <= done_n;
      err_pres_q <= err_pres_n;
      err_len_q  <= err_len_n;
      err_to_q   <= err_to_n;
    end
  end

  // Next-state and datapath logic.
  //
  // The first shift happens the cycle after done_reset, which is the cycle
  // the driver takes bit 0; shifting then leaves bit 1 on serial for the
  // first done_1bit. Every later done_1bit with rem != 0 hands over one more
  // bit. A done_1bit seen with rem == 0 means the driver has taken the last
  // bit and is heading to its all-done state.
  //
  // The watchdog runs in ARM, WAIT_PRES and SEND and is cleared by either
  // driver done flag. A done flag is tested before expiry, so a done flag
  // arriving on the expiry cycle wins. Both abort paths clear rem and shreg
  // so the strobe drops as soon as we are back in IDLE.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    rem_n       = rem;
    wdog_n      = wdog;
    pres_dly_n  = 1'b0;
    done_n      = 1'b0;
    err_pres_n  = 1'b0;
    err_len_n   = 1'b0;
    err_to_n    = 1'b0;
    o_drv_start = 1'b0;

    case (state)
      IDLE: begin
        if (i_req) begin
          if (len_ok) begin
            shreg_n = i_data;
            rem_n   = i_nbits;
            wdog_n  = '0;
            state_n = START;
          end else begin
            err_len_n = 1'b1;
          end
        end
      end

      START: begin
        o_drv_start = 1'b1;
        state_n     = ARM;
      end

      // The driver's busy flag is registered, so it is not yet valid in the
      // cycle right after start. This state simply waits it out.
      ARM: begin
        if (wdog_hit) begin
          err_to_n = 1'b1;
          shreg_n  = '0;
          rem_n    = '0;
          wdog_n   = '0;
          state_n  = IDLE;
        end else begin
          wdog_n  = wdog + WD_W'(1);
          state_n = WAIT_PRES;
        end
      end

      WAIT_PRES: begin
        if (i_drv_done_reset) begin
          pres_dly_n = 1'b1;
          wdog_n     = '0;
          state_n    = SEND;
        end else if (!i_drv_busy) begin
          err_pres_n = 1'b1;
          shreg_n    = '0;
          rem_n      = '0;
          wdog_n     = '0;
          state_n    = IDLE;
        end else if (wdog_hit) begin
          err_to_n = 1'b1;
          shreg_n  = '0;
          rem_n    = '0;
          wdog_n   = '0;
          state_n  = IDLE;
        end else begin
          wdog_n = wdog + WD_W'(1);
        end
      end

      SEND: begin
        if (i_drv_done_1bit) begin
          wdog_n = '0;
          if (rem != '0) begin
            shreg_n = {1'b0, shreg[MAX_BITS-1:1]};
            rem_n   = rem - CNT_W'(1);
          end else begin
            state_n = FINISH;
          end
        end else if (wdog_hit) begin
          err_to_n = 1'b1;
          shreg_n  = '0;
          rem_n    = '0;
          wdog_n   = '0;
          state_n  = IDLE;
        end else begin
          wdog_n = wdog + WD_W'(1);
          if (pres_dly && (rem != '0)) begin
            shreg_n = {1'b0, shreg[MAX_BITS-1:1]};
            rem_n   = rem - CNT_W'(1);
          end
        end
      end

      // o_drv_start stays low here so the driver cannot re-enter reset.
      FINISH: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
